// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one repeated-addition
// multiplier datapath among NREQ requesters. It grants one operand request,
// runs the datapath until its count reaches zero, then returns the product
// and the owner's index over a valid/ready response channel.
module mult_sched #(
    parameter int XLEN = 16,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*XLEN-1:0]    rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic                 dp_ld_input,
    output logic [1:0]           dp_state,
    output logic [XLEN-1:0]      dp_a,
    output logic [XLEN-1:0]      dp_b,
    input  logic                 dp_eqz,
    input  logic [2*XLEN-1:0]    dp_product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] DP_READY   = 2'd0;
    localparam logic [1:0] DP_OPERATE = 2'd1;
    localparam logic [1:0] DP_DONE    = 2'd2;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [2*XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    int                  scan_idx;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    // Operands always follow the current winner; only sampled on the load strobe.
    assign dp_a = req_a[int'(grant_idx)*XLEN +: XLEN];
    assign dp_b = req_b[int'(grant_idx)*XLEN +: XLEN];

    // Next-state logic and the combinational handshake / datapath controls.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        dp_ld_input = 1'b0;
        dp_state    = DP_READY;
        case (state_q)
            S_IDLE: begin
                // READY here also clears the datapath's partial product.
                dp_state = DP_READY;
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    dp_ld_input          = 1'b1;
                    id_d                 = grant_idx;
                    rr_ptr_d             = (int'(grant_idx) == NREQ - 1) ? '0
                                                                         : grant_idx + IDW'(1);
                    state_d              = S_RUN;
                end
            end
            S_RUN: begin
                if (dp_eqz) begin
                    // Count exhausted: product is valid this cycle, capture it.
                    dp_state    = DP_DONE;
                    rsp_data_d  = dp_product;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    dp_state = DP_OPERATE;
                end
            end
            S_RESP: begin
                dp_state = DP_DONE;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule
